alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Parametrised successor of the board-level ALU top.
- Operands and opcode come from switches, loaded under button control through an ordered entry state machine with edge-detected buttons.
- Result and status flags are registered and drive board LEDs.
- The ALU is implemented inside the block, with a one-cycle execute stage and a result-valid pulse.

Parameters:
- NB_DATA, 8, operand/result width (>=4)
- NB_OP, 6, opcode width (opcode taken from i_sw[NB_OP-1:0])
- NB_BTN, 3, button count (fixed meaning: [0]=A, [1]=B, [2]=OP)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_sw  in  NB_DATA  switch data for A, B or opcode
- i_btn  in  NB_BTN  load buttons, level
- o_led  out  NB_DATA  registered result
- o_zero  out  1  result==0
- o_carry  out  1  carry (ADD) / borrow (SUB)
- o_ovf  out  1  signed overflow (ADD/SUB)
- o_err  out  1  unsupported opcode
- o_valid  out  1  one-cycle pulse on each new result
- o_state  out  3  FSM state for debug LEDs

Behaviour:
- One clock domain: i_clk. Reset is synchronous, active-high on i_rst.
- Edge detect:
  - btn_q registers i_btn; pulse = i_btn & ~btn_q.
  - Reset loads btn_q to all ones, so a button held through reset produces no edge until it is released and pressed again.
- Simultaneous edges: priority A > B > OP. Lower-priority edges in the same cycle are discarded.
- FSM, with o_state encoding WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SHOW=4:
  - Any state, A edge: reg_a<=i_sw; go to WAIT_B. This restarts entry; reg_b and reg_op keep their old values.
  - WAIT_B, B edge: reg_b<=i_sw; go to WAIT_OP.
  - WAIT_OP, OP edge: reg_op<=i_sw[NB_OP-1:0]; go to EXEC.
  - EXEC: unconditional, one cycle. Result and flags are registered at the end of EXEC; go to SHOW.
  - SHOW, OP edge: reload reg_op; go to EXEC (re-execute with same A, B).
  - SHOW, B edge: reg_b<=i_sw; go to WAIT_OP.
  - Ignored, with state unchanged: B or OP edge in WAIT_A; OP edge in WAIT_B; any B or OP edge in EXEC.
  - Unused encodings go to WAIT_A.
- Latency: an OP edge sampled at clock edge k loads reg_op. o_led and the flags update at edge k+1. o_valid is high for exactly the cycle following edge k+1.
- o_led and the flags hold their values until the next EXEC or reset.
- Opcodes (NB_OP=6); operands are signed two's complement:
  - 100000 ADD: o_carry = bit NB_DATA of zero-extended sum; o_ovf = operand signs equal and result sign differs.
  - 100010 SUB A-B: o_carry = 1 when unsigned A<B (borrow); o_ovf = signs differ and result sign != sign of A.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 000011 SRA: A>>>B, arithmetic.
  - 000010 SRL: A>>B, logical.
  - Shift amount is B as unsigned. If B >= NB_DATA: SRA gives all sign bits, SRL gives 0.
  - o_carry and o_ovf are 0 for every non-ADD/SUB opcode.
  - Any other opcode: o_led=0, o_zero=0, o_carry=0, o_ovf=0, o_err=1. o_err clears on the next valid execute.
  - o_zero = (o_led==0) for valid opcodes.
- Reset at any point: state=WAIT_A; reg_a, reg_b, reg_op, o_led, all flags and o_valid = 0. An in-flight EXEC is abandoned and no o_valid pulse is issued.

Optional Feature:
- Macro: ALU_SEQ_BTN_SYNC_EN.
- Defined: i_btn passes through a 2-flop synchroniser before edge detection. The synchroniser flops reset to all ones. All button-to-load latencies grow by exactly 2 cycles.
- Undefined: i_btn feeds edge detection directly; no added latency.

Test Plan:
- Reset, A edge sw=0x7F, B edge sw=0x01, OP edge sw=0x20 -> o_led=0x80, o_ovf=1, o_carry=0, o_zero=0; o_valid high exactly 1 cycle, 1 cycle after the OP load edge.
- A=0x05, B=0x05, OP=0x22 -> o_led=0x00, o_zero=1, o_carry=0, o_ovf=0. Then, from SHOW, B edge sw=0x06 and OP edge 0x22 -> o_led=0xFF, o_carry=1, o_ovf=0.
- A=0x80, B=0x02, OP=0x03 -> o_led=0xE0. OP edge 0x02 from SHOW -> o_led=0x20. B edge sw=0x09 then OP edge 0x03 -> o_led=0xFF.
- From reset, B and OP edges before any A edge -> o_state stays 0, no o_valid. Then a simultaneous A+B edge with sw=0x11 -> reg_a=0x11, state=WAIT_B, B edge discarded.
- Button held high across reset release -> no load until release and re-press. Reset asserted in EXEC -> next cycle o_state=0, o_led=0, no o_valid.
- OP=0x3F after valid A, B -> o_led=0, o_err=1, o_valid pulses. Following OP=0x24 from SHOW -> o_err=0. Repeat the first scenario with ALU_SEQ_BTN_SYNC_EN defined -> same values, +2 cycle latency.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Board-level ALU sequencer. Operand A, operand B and the opcode are taken
//   from the switches on rising edges of three load buttons, in that order,
//   and the ALU result plus status flags are registered onto the LEDs after a
//   one-cycle execute state.
//
//   Ports
//     i_clk    system clock
//     i_rst    synchronous, active-high reset
//     i_sw     switch data (A, B, or opcode in i_sw[NB_OP-1:0])
//     i_btn    load buttons, level: [0]=A, [1]=B, [2]=OP
//     o_led    registered result
//     o_zero   result == 0 (valid opcodes only)
//     o_carry  carry (ADD) / borrow (SUB)
//     o_ovf    signed overflow (ADD/SUB)
//     o_err    unsupported opcode
//     o_valid  one-cycle pulse per new result
//     o_state  entry FSM state (WAIT_A=0 .. SHOW=4)
//
//   Build option
//     ALU_SEQ_BTN_SYNC_EN : when defined, i_btn goes through a 2-flop
//     synchroniser (reset to all ones) before edge detection, adding two
//     cycles to every button-to-load latency.

module alu_seq_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_BTN  = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic [NB_BTN-1:0]  i_btn,
  output logic [NB_DATA-1:0] o_led,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_err,
  output logic               o_valid,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

  // Shifts saturate once the amount reaches the word width.
  function automatic logic [NB_DATA-1:0] shift_ra(input logic signed [NB_DATA-1:0] a,
                                                  input logic [NB_DATA-1:0] sh);
    if (sh >= SHIFT_LIM) return {NB_DATA{a[NB_DATA-1]}};
    return a >>> sh;
  endfunction

  function automatic logic [NB_DATA-1:0] shift_rl(input logic [NB_DATA-1:0] a,
                                                  input logic [NB_DATA-1:0] sh);
    if (sh >= SHIFT_LIM) return '0;
    return a >> sh;
  endfunction

  state_t                    state, state_nxt;
  logic [NB_BTN-1:0]         btn_lvl, btn_q, btn_rise;
  logic                      a_evt, b_evt, op_evt;
  logic                      ld_a, ld_b, ld_op, exec_en;
  logic signed [NB_DATA-1:0] reg_a, reg_b;
  logic [NB_OP-1:0]          reg_op;
  logic [NB_DATA:0]          sum_ext, dif_ext;
  logic [NB_DATA-1:0]        alu_res;
  logic                      alu_carry, alu_ovf, alu_err;

  // ---- button input stage ----
`ifdef ALU_SEQ_BTN_SYNC_EN
  logic [NB_BTN-1:0] btn_sync_p0, btn_sync_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_sync_p0 <= '1;
      btn_sync_p1 <= '1;
    end else begin
      btn_sync_p0 <= i_btn;
      btn_sync_p1 <= btn_sync_p0;
    end
  end

  assign btn_lvl = btn_sync_p1;
`else
  assign btn_lvl = i_btn;
`endif

  // btn_q resets to ones so a button held through reset never looks like a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) btn_q <= '1;
    else       btn_q <= btn_lvl;
  end

  assign btn_rise = btn_lvl & ~btn_q;
  assign a_evt    = btn_rise[0];
  assign b_evt    = btn_rise[1] & ~btn_rise[0];
  assign op_evt   = btn_rise[2] & ~btn_rise[1] & ~btn_rise[0];

  // ---- entry stage ----
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_WAIT_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    if (a_evt) begin
      // A always restarts entry, from any state.
      ld_a      = 1'b1;
      state_nxt = S_WAIT_B;
    end else begin
      case (state)
        S_WAIT_A: state_nxt = S_WAIT_A;
        S_WAIT_B: begin
          if (b_evt) begin
            ld_b      = 1'b1;
            state_nxt = S_WAIT_OP;
          end
        end
        S_WAIT_OP: begin
          if (op_evt) begin
            ld_op     = 1'b1;
            state_nxt = S_EXEC;
          end else if (b_evt) begin
            ld_b      = 1'b1;
          end
        end
        S_EXEC: state_nxt = S_SHOW;
        S_SHOW: begin
          if (op_evt) begin
            ld_op     = 1'b1;
            state_nxt = S_EXEC;
          end else if (b_evt) begin
            ld_b      = 1'b1;
            state_nxt = S_WAIT_OP;
          end
        end
        default: state_nxt = S_WAIT_A;
      endcase
    end
  end

  assign exec_en = (state == S_EXEC);
  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_op <= '0;
    end else begin
      if (ld_a)  reg_a  <= i_sw;
      if (ld_b)  reg_b  <= i_sw;
      if (ld_op) reg_op <= i_sw[NB_OP-1:0];
    end
  end

  // ---- execute stage ----
  assign sum_ext = {1'b0, reg_a} + {1'b0, reg_b};
  assign dif_ext = {1'b0, reg_a} - {1'b0, reg_b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (reg_op)
      OP_ADD: begin
        alu_res   = sum_ext[NB_DATA-1:0];
        alu_carry = sum_ext[NB_DATA];
        alu_ovf   = (reg_a[NB_DATA-1] == reg_b[NB_DATA-1]) &&
                    (sum_ext[NB_DATA-1] != reg_a[NB_DATA-1]);
      end
      OP_SUB: begin
        alu_res   = dif_ext[NB_DATA-1:0];
        alu_carry = dif_ext[NB_DATA];  // borrow out == unsigned A < B
        alu_ovf   = (reg_a[NB_DATA-1] != reg_b[NB_DATA-1]) &&
                    (dif_ext[NB_DATA-1] != reg_a[NB_DATA-1]);
      end
      OP_AND:  alu_res = reg_a & reg_b;
      OP_OR:   alu_res = reg_a | reg_b;
      OP_XOR:  alu_res = reg_a ^ reg_b;
      OP_NOR:  alu_res = ~(reg_a | reg_b);
      OP_SRA:  alu_res = shift_ra(reg_a, reg_b);
      OP_SRL:  alu_res = shift_rl(reg_a, reg_b);
      default: alu_err = 1'b1;
    endcase
  end

  // ---- result stage ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_led   <= '0;
      o_zero  <= 1'b0;
      o_carry <= 1'b0;
      o_ovf   <= 1'b0;
      o_err   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= exec_en;
      if (exec_en) begin
        o_led   <= alu_res;
        o_zero  <= ~alu_err && (alu_res == '0);
        o_carry <= alu_carry;
        o_ovf   <= alu_ovf;
        o_err   <= alu_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Directed bench for alu_seq_ctrl. Buttons are driven one cycle wide after
//   an idle cycle; outputs are sampled 1 ns after the rising edge.

module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_BTN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_sw;
  logic [2:0] i_btn;
  logic [7:0] o_led;
  logic       o_zero, o_carry, o_ovf, o_err, o_valid;
  logic [2:0] o_state;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_ctrl #(.NB_DATA(8), .NB_OP(6), .NB_BTN(3)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sw    (i_sw),
    .i_btn   (i_btn),
    .o_led   (o_led),
    .o_zero  (o_zero),
    .o_carry (o_carry),
    .o_ovf   (o_ovf),
    .o_err   (o_err),
    .o_valid (o_valid),
    .o_state (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Idle cycle, then a one-cycle press; returns just after the load edge.
  task automatic press(input int idx, input logic [7:0] sw);
    tick();
    i_sw       = sw;
    i_btn[idx] = 1'b1;
    tick();
    i_btn[idx] = 1'b0;
    repeat (SYNC_LAT) tick();
  endtask

  // Called right after the OP load edge.
  task automatic exec_chk(input string tag, input logic [7:0] led, input logic z,
                          input logic c, input logic v, input logic e);
    chk({tag, ".state_exec"}, o_state, 3);
    chk({tag, ".valid_pre"}, o_valid, 0);
    tick();
    chk({tag, ".led"},   o_led,   led);
    chk({tag, ".zero"},  o_zero,  z);
    chk({tag, ".carry"}, o_carry, c);
    chk({tag, ".ovf"},   o_ovf,   v);
    chk({tag, ".err"},   o_err,   e);
    chk({tag, ".valid"}, o_valid, 1);
    chk({tag, ".state_show"}, o_state, 4);
    tick();
    chk({tag, ".valid_post"}, o_valid, 0);
    chk({tag, ".led_hold"}, o_led, led);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_btn = '0;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  initial begin
    i_rst = 1'b1;
    i_sw  = '0;
    i_btn = '0;
    do_reset();
    chk("rst.state", o_state, 0);
    chk("rst.led",   o_led,   0);
    chk("rst.valid", o_valid, 0);
    chk("rst.flags", {o_zero, o_carry, o_ovf, o_err}, 0);

    // 0x7F + 0x01: signed overflow
    press(0, 8'h7F);
    chk("s1.state_b", o_state, 1);
    press(1, 8'h01);
    chk("s1.state_op", o_state, 2);
    press(2, 8'h20);
    exec_chk("s1", 8'h80, 0, 0, 1, 0);

    // 5 - 5 = 0, then 5 - 6 borrows
    press(0, 8'h05);
    press(1, 8'h05);
    press(2, 8'h22);
    exec_chk("s2a", 8'h00, 1, 0, 0, 0);
    press(1, 8'h06);
    chk("s2.show_b_state", o_state, 2);
    press(2, 8'h22);
    exec_chk("s2b", 8'hFF, 0, 1, 0, 0);

    // Shifts, including saturating amount
    press(0, 8'h80);
    press(1, 8'h02);
    press(2, 8'h03);
    exec_chk("s3_sra", 8'hE0, 0, 0, 0, 0);
    press(2, 8'h02);
    exec_chk("s3_srl", 8'h20, 0, 0, 0, 0);
    press(1, 8'h09);
    press(2, 8'h03);
    exec_chk("s3_sra9", 8'hFF, 0, 0, 0, 0);

    // Out-of-order edges and simultaneous A+B
    do_reset();
    chk("s4.rst_led", o_led, 0);
    chk("s4.rst_state", o_state, 0);
    press(1, 8'h44);
    chk("s4.b_first_state", o_state, 0);
    press(2, 8'h20);
    chk("s4.op_first_state", o_state, 0);
    tick();
    chk("s4.no_valid", o_valid, 0);
    tick();
    i_sw  = 8'h11;
    i_btn = 3'b011;
    tick();
    i_btn = 3'b000;
    repeat (SYNC_LAT) tick();
    chk("s4.ab_state", o_state, 1);
    press(2, 8'h20);
    chk("s4.op_in_wait_b", o_state, 1);
    press(1, 8'h22);
    chk("s4.b_state", o_state, 2);
    press(2, 8'h20);
    exec_chk("s4", 8'h33, 0, 0, 0, 0);

    // Button held through reset release
    i_rst    = 1'b1;
    i_btn[0] = 1'b1;
    i_sw     = 8'h55;
    tick();
    tick();
    i_rst = 1'b0;
    repeat (4) tick();
    chk("s5.held_state", o_state, 0);
    i_btn[0] = 1'b0;
    press(0, 8'h03);
    chk("s5.repress_state", o_state, 1);
    press(1, 8'h04);
    press(2, 8'h20);
    exec_chk("s5", 8'h07, 0, 0, 0, 0);

    // Reset while in EXEC
    press(2, 8'h20);
    chk("s5.exec_state", o_state, 3);
    i_rst = 1'b1;
    tick();
    chk("s5.rexec_state", o_state, 0);
    chk("s5.rexec_led",   o_led,   0);
    chk("s5.rexec_valid", o_valid, 0);
    i_rst = 1'b0;
    tick();
    chk("s5.rexec_valid2", o_valid, 0);
    chk("s5.rexec_state2", o_state, 0);

    // Unsupported opcode, then recovery
    press(0, 8'h12);
    press(1, 8'h34);
    press(2, 8'h3F);
    exec_chk("s6_err", 8'h00, 0, 0, 0, 1);
    press(2, 8'h24);
    exec_chk("s6_and", 8'h10, 0, 0, 0, 0);
    press(2, 8'h27);
    exec_chk("s6_nor", 8'hC9, 0, 0, 0, 0);
    press(1, 8'hF0);
    press(2, 8'h20);
    exec_chk("s6_addc", 8'h02, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
